// File: rtl/sync_to_ncl_tx_if.sv
// Clocked source handshake plus dual-rail NCL channel for sync_to_ncl_tx.
// master = stimulus side, slave = transmitter.
interface sync_to_ncl_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rail1;
  logic [WIDTH-1:0] rail0;
  logic             ki;

  modport master (
    output in_data, in_valid, ki,
    input  in_ready, rail1, rail0
  );

  modport slave (
    input  in_data, in_valid, ki,
    output in_ready, rail1, rail0
  );
endinterface

// File: rtl/sync_to_ncl_tx.sv
// Clocked valid/ready to four-phase dual-rail NCL transmitter.
// Alternates whole-word DATA and NULL wavefronts paced by synchronized ki.
module sync_to_ncl_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  sync_to_ncl_tx_if.slave    bus,
  output logic               busy,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    NULL_PH = 2'd2
  } state_e;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       rail1_q, rail1_d;
  logic [WIDTH-1:0]       rail0_q, rail0_d;
  logic [15:0]            cnt_q, cnt_d, cnt_inc;
  logic                   err_q, err_d;
  logic [COUNT_W-1:0]     wc_q, wc_d;
  logic [SYNC_STAGES-1:0] ki_sync_q, ki_sync_d;
  logic                   ki_s;
  logic                   xfer;

  assign ki_s = ki_sync_q[SYNC_STAGES-1];
  assign xfer = (state_q == IDLE) && ki_s && bus.in_valid;

  always_comb begin
    ki_sync_d = {ki_sync_q[SYNC_STAGES-2:0], bus.ki};
    state_d   = state_q;
    rail1_d   = rail1_q;
    rail0_d   = rail0_q;
    wc_d      = wc_q;
    cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    cnt_d     = 16'd0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = DATA;
          rail1_d = bus.in_data;
          rail0_d = ~bus.in_data;
        end
      end
      DATA: begin
        if (!ki_s) begin
          state_d = NULL_PH;
          rail1_d = '0;
          rail0_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      NULL_PH: begin
        if (ki_s) begin
          state_d = IDLE;
          wc_d    = wc_q + COUNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        rail1_d = '0;
        rail0_d = '0;
      end
    endcase
    // sticky: the FSM keeps waiting, only the flag records the stall
    err_d = err_q || (cnt_d >= TO_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rail1_q   <= '0;
      rail0_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wc_q      <= '0;
      ki_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      rail1_q   <= rail1_d;
      rail0_q   <= rail0_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wc_q      <= wc_d;
      ki_sync_q <= ki_sync_d;
    end
  end

  assign bus.rail1    = rail1_q;
  assign bus.rail0    = rail0_q;
  assign bus.in_ready = (state_q == IDLE) && ki_s;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = err_q;
  assign word_count   = wc_q;

endmodule

// File: doc/sync_to_ncl_tx.md
Name: sync_to_ncl_tx

Overview:
- Clocked-to-NCL transmitter. Accepts a binary word from a synchronous valid/ready source and drives it onto a dual-rail NCL channel as alternating DATA and NULL wavefronts.
- Sequences the wavefronts using the receiving NCL stage's completion acknowledge (ki).
- It is the sending end of the four-phase dual-rail channel that the team's threshold-gate stages (TH-family, e.g. weighted 3-of-3 completion cells) consume and acknowledge.
- It sits at the boundary where the clocked test/stimulus domain feeds an NCL pipeline.

Parameters:
- WIDTH, 8, number of dual-rail bits (binary word width).
- SYNC_STAGES, 2, flip-flop stages synchronizing ki into clk domain (min 2).
- TIMEOUT, 255, clk cycles a handshake phase may wait before timeout_err is set (1..65535).
- COUNT_W, 16, width of the completed-word counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, WIDTH, binary word to send.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, block accepts in_data this cycle.
- rail1, output, WIDTH, dual-rail true rails; bit i high = DATA 1.
- rail0, output, WIDTH, dual-rail false rails; bit i high = DATA 0.
- ki, input, 1, acknowledge from receiver completion: 1 = request-for-data (rfd), 0 = request-for-null (rfn); asynchronous to clk.
- busy, output, 1, a wavefront cycle is in progress (state != IDLE).
- timeout_err, output, 1, sticky; a phase exceeded TIMEOUT cycles.
- word_count, output, COUNT_W, number of completed DATA+NULL cycles, wraps.

Behaviour:
- Reset (async, immediate):
  - rail1 = rail0 = 0 (NULL).
  - state = IDLE; in_ready = 0, busy = 0, timeout_err = 0, word_count = 0.
  - All ki sync flops = 0, so ki_s = 0.
- Reset mid-wavefront: rails drop to NULL immediately; the in-flight word is discarded and not counted.
- ki_s is ki delayed through SYNC_STAGES flops. Only ki_s is used internally.
- All outputs are registered; no combinational path from ki or in_data to rails.
- in_ready = (state==IDLE) && ki_s. It is combinational from registered state only. Transfer occurs when in_valid && in_ready at a rising edge.
- Rails invariant: never rail1[i] && rail0[i]. Rails switch as a whole word on a single edge (all-NULL <-> all-DATA); no partial wavefronts.
- FSM:
  - IDLE: rails NULL. On transfer → DATA; rail1 <= in_data, rail0 <= ~in_data, phase counter cleared.
  - DATA: rails hold DATA. When ki_s == 0 → NULL_PH; rails <= 0, counter cleared.
  - NULL_PH: rails NULL. When ki_s == 1 → IDLE; word_count += 1 (mod 2^COUNT_W).
- Latency:
  - Rails show DATA on the edge that performs the transfer.
  - ki falling → rails NULL after SYNC_STAGES+1 edges.
  - ki rising → back to IDLE after SYNC_STAGES+1 edges. in_ready asserts in that same cycle, so back-to-back words are possible with no extra bubble.
- in_data/in_valid are ignored outside IDLE. in_valid may drop without a transfer; nothing is driven.
- Phase counter: 16-bit.
  - Counts cycles spent in DATA or NULL_PH and saturates.
  - When it reaches TIMEOUT, timeout_err <= 1 (sticky until rst).
  - The FSM keeps waiting; there is no abort.
  - Not counted in IDLE.
- ki held low in IDLE (receiver not ready): in_ready stays 0 and rails stay NULL.
- ki glitch shorter than one clk period: may be missed or seen. The design must not corrupt rails. The protocol assumes ki is stable per phase.
- Simultaneous: if ki_s changes on the same edge as the transfer, the transfer still occurs. The DATA state evaluates ki_s from the next edge onward.

Test Plan:
- Reset then ki=1: in_ready rises SYNC_STAGES edges after rst release. With rails=0 and word_count=0, in_data=8'hA5, in_valid=1 → next edge rail1=8'hA5, rail0=8'h5A, busy=1, in_ready=0.
- From DATA, drop ki → exactly 3 edges later (SYNC_STAGES=2) rails=0. Raise ki → 3 edges later state IDLE, word_count=1, in_ready=1.
- Back-to-back stream 8'h00, 8'hFF, 8'h3C with an ideal responder (ki follows rails completion after 1 cycle):
  - Rails alternate DATA/NULL with correct encodings.
  - No bit ever has both rails high.
  - word_count=3.
- Responder never drops ki while in DATA: timeout_err sets after exactly 255 cycles in DATA and rails hold DATA. Later drop ki → normal completion; timeout_err stays 1.
- Assert rst while DATA 8'h81 is on the rails: rails=0 asynchronously (before the next edge), word_count unchanged at 0, timeout_err=0.
- COUNT_W=4, run 17 words → word_count wraps to 1. With ki held 0 in IDLE and in_valid=1 for 50 cycles, in_ready stays 0 and rails stay 0.
